// File: rtl/bitmask_assembler_pkg.sv
// Shared definitions for the bitmask assembler.
//   WIDTH    : assembled mask width
//   IDX_W    : index port width, clog2(WIDTH)+1 so that NONE_IDX and the
//              illegal range above it are representable
//   NONE_IDX : index value meaning "no bit" (the scanner's encoding of zero)
//   state_t  : FSM encoding, ACC collects beats, OUT presents the word
package bitmask_assembler_pkg;

  localparam int WIDTH    = 32;
  localparam int IDX_W    = $clog2(WIDTH) + 1;
  localparam int NONE_IDX = 32;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

endpackage

// File: rtl/bitmask_assembler_idx_decoder.sv
// Combinational index decoder for the bitmask assembler.
// Ports:
//   idx       in  IDX_W  bit index from the scanner stream
//   onehot    out WIDTH  one-hot of idx when idx < WIDTH, otherwise zero
//   valid_bit out 1      idx addresses a real bit (idx < WIDTH)
//   illegal   out 1      idx lies above NONE_IDX
module bitmask_assembler_idx_decoder
  import bitmask_assembler_pkg::*;
#(
  parameter int WIDTH    = bitmask_assembler_pkg::WIDTH,
  parameter int NONE_IDX = bitmask_assembler_pkg::NONE_IDX,
  localparam int IDX_W   = $clog2(WIDTH) + 1
) (
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] onehot,
  output logic             valid_bit,
  output logic             illegal
);

  assign valid_bit = (idx < IDX_W'(WIDTH));
  assign illegal   = (idx > IDX_W'(NONE_IDX));

  // The top index bit is only set for NONE_IDX and the illegal range, so
  // the low bits alone select the mask position once valid_bit holds.
  always_comb begin
    onehot = '0;
    if (valid_bit) begin
      onehot[idx[IDX_W-2:0]] = 1'b1;
    end
  end

endmodule

// File: rtl/bitmask_assembler.sv
// Bitmask assembler: rebuilds a WIDTH-bit mask from a stream of bit indices
// (the inverse of the lowbit scanner). Indices are OR-accumulated until a
// beat flagged last, then the word and its status are held on the output
// port until consumed.
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   in_valid/in_ready  input handshake; in_ready is high only in ACC
//   in_idx             bit index: <WIDTH sets a bit, NONE_IDX is a no-op,
//                      anything above NONE_IDX is flagged as an error
//   in_last            accepted beat closes the current word
//   out_valid/out_ready output handshake; out_valid is high only in OUT
//   out_word           assembled mask
//   out_count          number of distinct bits set in out_word
//   out_dup            some accepted index hit an already-set bit
//   out_err            some accepted index was above NONE_IDX
module bitmask_assembler
  import bitmask_assembler_pkg::*;
#(
  parameter int WIDTH    = bitmask_assembler_pkg::WIDTH,
  parameter int NONE_IDX = bitmask_assembler_pkg::NONE_IDX,
  localparam int IDX_W   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [IDX_W-1:0] out_count,
  output logic             out_dup,
  output logic             out_err
);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] acc;
  logic [IDX_W-1:0] count;
  logic             dup;
  logic             err;

  logic [WIDTH-1:0] onehot;
  logic             valid_bit;
  logic             illegal;

  logic             accept;
  logic             out_fire;
  logic             dup_hit;
  logic             new_bit;

  logic [WIDTH-1:0] acc_nxt;
  logic [IDX_W-1:0] count_nxt;
  logic             dup_nxt;
  logic             err_nxt;

  bitmask_assembler_idx_decoder #(
    .WIDTH    (WIDTH),
    .NONE_IDX (NONE_IDX)
  ) u_idx_decoder (
    .idx       (in_idx),
    .onehot    (onehot),
    .valid_bit (valid_bit),
    .illegal   (illegal)
  );

  // Both handshake outputs are pure decodes of the state register, so
  // nothing on the input side reaches the output side combinationally.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // count only advances on a previously clear bit, so it tops out at WIDTH
  // and can never wrap in IDX_W bits.
  assign dup_hit   = |(onehot & acc);
  assign new_bit   = valid_bit && !dup_hit;
  assign acc_nxt   = acc | onehot;
  assign count_nxt = count + {{(IDX_W-1){1'b0}}, new_bit};
  assign dup_nxt   = dup | dup_hit;
  assign err_nxt   = err | illegal;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACC: if (accept && in_last) state_nxt = OUT;
      OUT: if (out_ready)         state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Accumulator and output holding registers. The holding registers take
  // the *_nxt values so the closing beat is included in the presented word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      count     <= '0;
      dup       <= 1'b0;
      err       <= 1'b0;
      out_word  <= '0;
      out_count <= '0;
      out_dup   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (accept) begin
        acc   <= acc_nxt;
        count <= count_nxt;
        dup   <= dup_nxt;
        err   <= err_nxt;
        if (in_last) begin
          out_word  <= acc_nxt;
          out_count <= count_nxt;
          out_dup   <= dup_nxt;
          out_err   <= err_nxt;
        end
      end
      // accept and out_fire are exclusive (ACC vs OUT), so this cannot
      // clobber a beat taken in the same cycle.
      if (out_fire) begin
        acc   <= '0;
        count <= '0;
        dup   <= 1'b0;
        err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitmask_assembler.sv
// Self-checking bench for bitmask_assembler: a driver feeds index beats and
// pushes each completed word's expected result into a queue; a monitor pops
// and compares whenever the DUT presents a word.
module tb_bitmask_assembler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_idx = 6'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic [5:0]  out_count;
  logic        out_dup;
  logic        out_err;

  always #5 clk = ~clk;

  bitmask_assembler dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_count (out_count),
    .out_dup   (out_dup),
    .out_err   (out_err)
  );

  typedef struct {
    logic [31:0] w;
    int          c;
    bit          d;
    bit          e;
    int          cy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rmode = 0;     // 0: out_ready high, 1: random, 2: held low
  bit   seen[32];
  bit   m_dup = 0;
  bit   m_err = 0;
  bit   prev_valid = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 32; i++) seen[i] = 0;
    m_dup = 0;
    m_err = 0;
  endfunction

  // Reference model: a set of bit positions plus two sticky flags.
  function automatic void model_accept(logic [5:0] idx, bit last);
    exp_t e;
    int   v;
    v = int'(idx);
    if (v < 32) begin
      if (seen[v]) m_dup = 1;
      else         seen[v] = 1;
    end else if (v > 32) begin
      m_err = 1;
    end
    if (last) begin
      e.w = 32'h0;
      e.c = 0;
      for (int i = 0; i < 32; i++) begin
        if (seen[i]) begin
          e.w[i] = 1'b1;
          e.c++;
        end
      end
      e.d  = m_dup;
      e.e  = m_err;
      e.cy = cyc;
      q.push_back(e);
      clear_model();
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 1) == 1);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: compare every cycle the word is presented, pop on handshake.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 0;
    end else begin
      if (out_valid) begin
        chk("in_ready_in_out", 32'(in_ready), 32'd0);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word actual=%0h required=none", out_word);
        end else begin
          chk("out_word",  out_word,         q[0].w);
          chk("out_count", 32'(out_count),   32'(q[0].c));
          chk("out_dup",   32'(out_dup),     32'(q[0].d));
          chk("out_err",   32'(out_err),     32'(q[0].e));
          if (!prev_valid) chk("latency", 32'(cyc), 32'(q[0].cy + 1));
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        chk("in_ready_in_acc", 32'(in_ready), 32'd1);
      end
      prev_valid = out_valid;
    end
  end

  // Drive one beat and hold it until accepted. Called at posedge+1.
  task automatic send(input logic [5:0] idx, input bit last);
    int n;
    bit done;
    n = 0;
    done = 0;
    in_valid = 1'b1;
    in_idx   = idx;
    in_last  = last;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !reset) begin
        model_accept(idx, last);
        done = 1;
      end else if (++n > 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout actual=stalled required=accepted idx=%0d", idx);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=pending%0d required=0", q.size());
    end
  endtask

  initial begin
    int len;
    int r;
    logic [5:0] idx;
    clear_model();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_word",  out_word,       32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_dup",   32'(out_dup),   32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // idx 0, 5, 31 -> 0x80000021, count 3
    send(6'd0, 0); send(6'd5, 0); send(6'd31, 1);
    // lone NONE_IDX beat -> empty word
    send(6'd32, 1);
    // duplicate and illegal index
    send(6'd4, 0); send(6'd4, 0); send(6'd40, 1);
    // every bit -> all ones, count 32
    for (int i = 0; i < 32; i++) send(6'(i), (i == 31));

    // backpressure: word 0x80 held while the next beat waits
    wait_drain();
    rmode = 2;
    @(posedge clk);
    #1;
    send(6'd7, 1);
    fork
      send(6'd3, 1);
      begin
        repeat (5) @(posedge clk);
        rmode = 0;
      end
    join

    // async reset mid-word discards the partial word and clears outputs
    wait_drain();
    send(6'd2, 0);
    send(6'd9, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out_word",  out_word,       32'd0);
    chk("async_rst_out_count", 32'(out_count), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready",  32'(in_ready),  32'd1);
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(6'd1, 1);

    // randomized words with random output backpressure
    rmode = 1;
    for (int w = 0; w < 40; w++) begin
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        r = $urandom_range(0, 9);
        if (r < 6)       idx = 6'($urandom_range(0, 31));
        else if (r < 8)  idx = 6'($urandom_range(0, 3));
        else if (r == 8) idx = 6'd32;
        else             idx = 6'($urandom_range(33, 63));
        send(idx, (b == len - 1));
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    end
    rmode = 0;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
